// File: rtl/aes_sub_bytes_seq.sv
// ============================================================================
// Module   : aes_sub_bytes_seq (with helper aes_sbox)
// Brief    : Iterative SubBytes engine sharing NUM_SBOX S-boxes between the
//            128-bit state and 32-bit key-schedule SubWord requests.
//            Optional macro AES_SBSEQ_STATS_EN adds sb_count / kw_count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_sbox (
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] w_sq;
  logic [7:0] w_inv;

  // Multiplicative inverse as x^254 (0 maps to 0), followed by the affine map.
  always_comb begin
    w_sq  = data_in;
    w_inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      w_sq  = gf_mul(w_sq, w_sq);
      w_inv = gf_mul(w_inv, w_sq);
    end
    data_out = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
             ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_sub_bytes_seq #(
  parameter int NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  input  logic         kw_req,
  input  logic [31:0]  kw_word,
  output logic         kw_ack,
  output logic [31:0]  kw_result,
  output logic         busy
`ifdef AES_SBSEQ_STATS_EN
  ,
  output logic [31:0]  sb_count,
  output logic [15:0]  kw_count
`endif
);

  localparam int SB_PASSES  = 16 / NUM_SBOX;
  localparam int KW_PASSES  = (NUM_SBOX >= 4) ? 1 : 4 / NUM_SBOX;
  localparam int c_kw_lanes = (NUM_SBOX >= 4) ? 4 : NUM_SBOX;
  localparam int c_pass_w   = (SB_PASSES > 1) ? $clog2(SB_PASSES) : 1;

  localparam logic [c_pass_w-1:0] c_sb_last  = c_pass_w'(SB_PASSES - 1);
  localparam logic [c_pass_w-1:0] c_kw_last  = c_pass_w'(KW_PASSES - 1);
  localparam logic [c_pass_w-1:0] c_pass_one = c_pass_w'(1);

  if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
        NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
    $error("aes_sub_bytes_seq: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SB_RUN  = 3'd1,
    SB_DONE = 3'd2,
    KW_RUN  = 3'd3,
    KW_ACK  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [c_pass_w-1:0]   r_pass;
  logic [127:0]          r_in;
  logic [31:0]           r_kw_in;
  logic [127:0]          r_state_out;
  logic [31:0]           r_kw_result;
  logic                  r_last_kw;
  logic                  w_sb_grant;
  logic                  w_kw_grant;
  logic [3:0]            w_base;
  logic [NUM_SBOX*8-1:0] w_lane_out;
  logic [7:0]            w_in_bytes [16];
  logic [7:0]            w_kw_bytes [4];

  // A pending SubWord request blocks new state only when SB was served last.
  assign in_ready  = !rst && (r_state == IDLE) && !(kw_req && !r_last_kw);
  assign out_valid = (r_state == SB_DONE);
  assign kw_ack    = (r_state == KW_ACK);
  assign busy      = (r_state != IDLE);
  assign state_out = r_state_out;
  assign kw_result = r_kw_result;
  assign w_base    = 4'(r_pass) * 4'(NUM_SBOX);

  for (genvar b = 0; b < 16; b++) begin : g_split_state
    assign w_in_bytes[b] = r_in[b*8 +: 8];
  end

  for (genvar b = 0; b < 4; b++) begin : g_split_word
    assign w_kw_bytes[b] = r_kw_in[b*8 +: 8];
  end

  for (genvar l = 0; l < NUM_SBOX; l++) begin : g_lane
    logic [3:0] w_idx;
    logic [7:0] w_lane_in;
    logic [7:0] w_sbox_out;

    assign w_idx = w_base + 4'(l);

    if (l < c_kw_lanes) begin : g_kw_lane
      always_comb begin
        w_lane_in = 8'h00;
        if (r_state == SB_RUN)
          w_lane_in = w_in_bytes[w_idx];
        else if (r_state == KW_RUN)
          w_lane_in = w_kw_bytes[w_idx[1:0]];
      end
    end else begin : g_sb_lane
      assign w_lane_in = (r_state == SB_RUN) ? w_in_bytes[w_idx] : 8'h00;
    end

    aes_sbox u_sbox (
      .data_in  (w_lane_in),
      .data_out (w_sbox_out)
    );

    assign w_lane_out[l*8 +: 8] = w_sbox_out;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_sb_grant = 1'b0;
    w_kw_grant = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid && in_ready) begin
          w_sb_grant = 1'b1;
          w_next     = SB_RUN;
        end else if (kw_req) begin
          w_kw_grant = 1'b1;
          w_next     = KW_RUN;
        end
      end
      SB_RUN:  if (r_pass == c_sb_last) w_next = SB_DONE;
      SB_DONE: if (out_ready) w_next = IDLE;
      KW_RUN:  if (r_pass == c_kw_last) w_next = KW_ACK;
      KW_ACK:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pass      <= '0;
      r_in        <= '0;
      r_kw_in     <= '0;
      r_state_out <= '0;
      r_kw_result <= '0;
      r_last_kw   <= 1'b0;
    end else begin
      if (w_sb_grant) begin
        r_in      <= state_in;
        r_pass    <= '0;
        r_last_kw <= 1'b0;
      end else if (w_kw_grant) begin
        r_kw_in   <= kw_word;
        r_pass    <= '0;
        r_last_kw <= 1'b1;
      end else if (r_state == SB_RUN || r_state == KW_RUN) begin
        r_pass <= (w_next != r_state) ? '0 : r_pass + c_pass_one;
      end

      if (r_state == SB_RUN) begin
        for (int l = 0; l < NUM_SBOX; l++)
          r_state_out[(int'(w_base) + l)*8 +: 8] <= w_lane_out[l*8 +: 8];
      end

      if (r_state == KW_RUN) begin
        for (int l = 0; l < c_kw_lanes; l++)
          r_kw_result[(int'(w_base) + l)*8 +: 8] <= w_lane_out[l*8 +: 8];
      end
    end
  end

`ifdef AES_SBSEQ_STATS_EN
  logic [31:0] r_sb_count;
  logic [15:0] r_kw_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb_count <= '0;
      r_kw_count <= '0;
    end else begin
      if (out_valid && out_ready) r_sb_count <= r_sb_count + 32'd1;
      if (kw_ack)                 r_kw_count <= r_kw_count + 16'd1;
    end
  end

  assign sb_count = r_sb_count;
  assign kw_count = r_kw_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_sub_bytes_seq.sv
// ============================================================================
// Module   : tb_aes_sub_bytes_seq
// Brief    : Self-checking bench for aes_sub_bytes_seq against an S-box model
//            built by brute-force GF(2^8) inversion.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_sub_bytes_seq;

  parameter int NUM_SBOX = 4;
  localparam int SB_PASSES = 16 / NUM_SBOX;
  localparam int KW_PASSES = (NUM_SBOX >= 4) ? 1 : 4 / NUM_SBOX;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         kw_req;
  logic [31:0]  kw_word;
  logic         kw_ack;
  logic [31:0]  kw_result;
  logic         busy;
`ifdef AES_SBSEQ_STATS_EN
  logic [31:0]  sb_count;
  logic [15:0]  kw_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] sbox_ref [256];
  logic       last_sb;

  always #5 clk = ~clk;

  aes_sub_bytes_seq #(.NUM_SBOX(NUM_SBOX)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .kw_req    (kw_req),
    .kw_word   (kw_word),
    .kw_ack    (kw_ack),
    .kw_result (kw_result),
    .busy      (busy)
`ifdef AES_SBSEQ_STATS_EN
    ,
    .sb_count  (sb_count),
    .kw_count  (kw_count)
`endif
  );

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_ref();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_ref[x] = s;
    end
  endtask

  function automatic logic [127:0] ref_sub_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = sbox_ref[s[i*8 +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] ref_sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = sbox_ref[w[i*8 +: 8]];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Presents state_in and returns just after the accepting edge.
  task automatic sb_send(input logic [127:0] d, input string tag);
    int n;
    n = 0;
    state_in = d;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (n >= 40) begin
      bad++;
      $display("FAIL %s_accept: in_ready=%b want 1", tag, in_ready);
    end
    tick();
    in_valid = 1'b0;
    state_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(output int lat, input string tag);
    lat = 0;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
    end
    total++;
    if (!out_valid) begin
      bad++;
      $display("FAIL %s_out_timeout: out_valid=%b want 1", tag, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; kw_req = 1'b0;
    state_in = '0; kw_word = '0;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_early: got %b want 0", in_ready); end
    tick(); tick();
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    total++;
    if ({busy, out_valid, kw_ack, in_ready} !== 4'b0001) begin
      bad++; $display("FAIL reset_flags: busy/out_valid/kw_ack/in_ready got %b want 0001",
                      {busy, out_valid, kw_ack, in_ready});
    end
    total++;
    if (state_out !== 128'h0 || kw_result !== 32'h0) begin
      bad++; $display("FAIL reset_data: state_out=%h kw_result=%h want zeros", state_out, kw_result);
    end
  endtask

  task automatic test_sb_counting();
    logic [127:0] d;
    int lat;
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(i);
    out_ready = 1'b1;
    sb_send(d, "count");
    wait_out(lat, "count");
    total++;
    if (lat !== SB_PASSES) begin bad++; $display("FAIL sb_latency: got %0d want %0d", lat, SB_PASSES); end
    total++;
    if (state_out !== 128'h76abd7fe2b670130c56f6bf27b777c63) begin
      bad++; $display("FAIL sb_known_vector: got %h want 76abd7fe2b670130c56f6bf27b777c63", state_out);
    end
    total++;
    if (state_out !== ref_sub_state(d)) begin
      bad++; $display("FAIL sb_model: got %h want %h", state_out, ref_sub_state(d));
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL sb_release: out_valid=%b busy=%b want 0 0", out_valid, busy);
    end
`ifdef AES_SBSEQ_STATS_EN
    total++;
    if (sb_count !== 32'd1 || kw_count !== 16'd0) begin
      bad++; $display("FAIL stats_after_sb: sb_count=%0d kw_count=%0d want 1 0", sb_count, kw_count);
    end
`endif
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    sb_send(128'h0, "bp");
    wait_out(lat, "bp");
    for (int c = 0; c < 5; c++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || state_out !== {16{8'h63}}) begin
        bad++; $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b state_out=%h want 1 0 %h",
                        c, out_valid, in_ready, state_out, {16{8'h63}});
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_before_release: out_valid=%b want 1", out_valid); end
    tick();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_idle: out_valid=%b busy=%b in_ready=%b want 0 0 1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_kw();
    int lat;
    kw_word = 32'h00000053;
    kw_req  = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL kw_blocks_in_ready: got %b want 0", in_ready); end
    tick();
    kw_word = 32'hdeadbeef;
    lat = 0;
    while (!kw_ack && lat < 64) begin
      tick();
      lat++;
    end
    total++;
    if (lat !== KW_PASSES || kw_ack !== 1'b1) begin
      bad++; $display("FAIL kw_latency: got %0d ack=%b want %0d 1", lat, kw_ack, KW_PASSES);
    end
    total++;
    if (kw_result !== 32'h636363ed || kw_result !== ref_sub_word(32'h00000053)) begin
      bad++; $display("FAIL kw_result: got %h want 636363ed", kw_result);
    end
    kw_req = 1'b0;
    tick();
    total++;
    if (kw_ack !== 1'b0 || busy !== 1'b0 || kw_result !== 32'h636363ed) begin
      bad++; $display("FAIL kw_after_ack: ack=%b busy=%b kw_result=%h want 0 0 636363ed", kw_ack, busy, kw_result);
    end
    total++;
    if (state_out !== {16{8'h63}}) begin
      bad++; $display("FAIL kw_state_out_kept: got %h want %h", state_out, {16{8'h63}});
    end
`ifdef AES_SBSEQ_STATS_EN
    total++;
    if (kw_count !== 16'd1) begin bad++; $display("FAIL stats_kw: kw_count=%0d want 1", kw_count); end
`endif
  endtask

  task automatic test_arbitration();
    logic [127:0] d;
    logic [31:0]  w1;
    logic [31:0]  w2;
    int           n;
    int           lat;
    d  = {$urandom, $urandom, $urandom, $urandom};
    w1 = $urandom;
    w2 = $urandom;
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1; state_in = d;
    kw_req    = 1'b1; kw_word  = w1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL arb_first_kw: in_ready=%b want 0", in_ready); end
    tick();
    n = 0;
    while (!kw_ack && n < 64) begin tick(); n++; end
    total++;
    if (kw_ack !== 1'b1 || kw_result !== ref_sub_word(w1)) begin
      bad++; $display("FAIL arb_kw_result: ack=%b got %h want %h", kw_ack, kw_result, ref_sub_word(w1));
    end
    kw_word = w2;
    tick();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL arb_alternate_sb: in_ready=%b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    wait_out(lat, "arb");
    total++;
    if (state_out !== ref_sub_state(d)) begin
      bad++; $display("FAIL arb_sb_result: got %h want %h", state_out, ref_sub_state(d));
    end
    tick();
    n = 0;
    while (!kw_ack && n < 64) begin tick(); n++; end
    total++;
    if (kw_ack !== 1'b1 || kw_result !== ref_sub_word(w2)) begin
      bad++; $display("FAIL arb_kw2_result: ack=%b got %h want %h", kw_ack, kw_result, ref_sub_word(w2));
    end
    kw_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [127:0] d;
    logic         seen;
    int           lat;
    out_ready = 1'b1;
    sb_send({$urandom, $urandom, $urandom, $urandom}, "mid");
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || state_out !== 128'h0) begin
      bad++; $display("FAIL mid_reset: busy=%b out_valid=%b state_out=%h want 0 0 0", busy, out_valid, state_out);
    end
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid || kw_ack) seen = 1'b1;
      tick();
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL mid_no_stale_output: seen=%b want 0", seen); end
    d = {$urandom, $urandom, $urandom, $urandom};
    sb_send(d, "mid2");
    wait_out(lat, "mid2");
    total++;
    if (state_out !== ref_sub_state(d)) begin
      bad++; $display("FAIL mid_recover: got %h want %h", state_out, ref_sub_state(d));
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    last_sb = 1'b1;
    for (int it = 0; it < 24; it++) begin
      logic         want_sb, want_kw, exp_first_kw, first_seen, g_sb, g_kw;
      logic [127:0] d;
      logic [31:0]  w;
      int           n_sb, n_kw, cyc;
      want_sb = 1'($urandom_range(0, 1));
      want_kw = 1'($urandom_range(0, 1));
      if (!want_sb && !want_kw) want_sb = 1'b1;
      exp_first_kw = want_kw && (!want_sb || last_sb);
      d = {$urandom, $urandom, $urandom, $urandom};
      w = $urandom;
      in_valid = want_sb; state_in = d;
      kw_req   = want_kw; kw_word  = w;
      first_seen = 1'b0; n_sb = 0; n_kw = 0; cyc = 0;
      #1;
      while ((in_valid || kw_req || busy) && cyc < 300) begin
        g_sb = in_valid && in_ready;
        g_kw = kw_req && !busy && !g_sb;
        if ((g_sb || g_kw) && !first_seen) begin
          first_seen = 1'b1;
          total++;
          if (g_kw !== exp_first_kw) begin
            bad++; $display("FAIL rnd%0d_order: kw_first=%b want %b", it, g_kw, exp_first_kw);
          end
        end
        if (g_sb) last_sb = 1'b1;
        if (g_kw) last_sb = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          n_sb++;
          total++;
          if (state_out !== ref_sub_state(d)) begin
            bad++; $display("FAIL rnd%0d_sb: got %h want %h", it, state_out, ref_sub_state(d));
          end
        end
        if (kw_ack) begin
          n_kw++;
          total++;
          if (kw_result !== ref_sub_word(w)) begin
            bad++; $display("FAIL rnd%0d_kw: got %h want %h", it, kw_result, ref_sub_word(w));
          end
          kw_req = 1'b0;
        end
        tick();
        if (g_sb) begin in_valid = 1'b0; state_in = {$urandom, $urandom, $urandom, $urandom}; end
        if (g_kw) kw_word = $urandom;
        cyc++;
      end
      total++;
      if (n_sb !== int'(want_sb) || n_kw !== int'(want_kw) || cyc >= 300) begin
        bad++; $display("FAIL rnd%0d_done: sb=%0d kw=%0d cyc=%0d want %0d %0d <300",
                        it, n_sb, n_kw, cyc, want_sb, want_kw);
      end
    end
    in_valid = 1'b0;
    kw_req = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    build_ref();
    test_reset();
    test_sb_counting();
    test_backpressure();
    test_kw();
    test_arbitration();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
